popcount_seq: RTL
=================

Name: popcount_seq

Overview:
- Parametrised, multi-cycle population counter: counts the ones in a WIDTH-bit word, CHUNK bits per clock.
- Generalises the team's 8-bit combinational ones counter to arbitrary width with a start/busy/done handshake.
- Optional running total across words: saturating accumulator with sticky overflow flag.
- Sits beside datapath blocks that need bit-weight statistics without a wide single-cycle adder tree.

Parameters:
- WIDTH, 32, input word width; must be >= 1.
- CHUNK, 4, bits counted per cycle; must be >= 1, <= WIDTH, and divide WIDTH exactly.
- ACC_W, 16, width of running total; must be >= CW.
- Derived:
  - K = WIDTH/CHUNK, number of count cycles.
  - CW = $clog2(WIDTH+1), width of count.
- Illegal parameter combinations stop elaboration via a generate-time check.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- din  in  WIDTH  word to count; captured on the accepting edge
- acc_en  in  1  add this word's count to total; captured with din
- clear  in  1  synchronous clear of total and total_ovf
- busy  out  1  high while a word is being counted
- done  out  1  one-cycle pulse; count valid
- count  out  CW  ones in the last completed word
- total  out  ACC_W  saturating running sum
- total_ovf  out  1  sticky saturation flag

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - busy=0, done=0, count=0, total=0, total_ovf=0.
  - Shift register, partial sum and chunk counter are cleared.
- States are IDLE, BUSY, DONE.
- IDLE:
  - When start=1 at edge N: load shift register with din, latch acc_en, partial sum=0, chunk index=0, go to BUSY.
  - busy=1 from edge N.
  - start=0: stay in IDLE.
- BUSY:
  - Each edge adds the popcount of the low CHUNK bits of the shift register to the partial sum, then shifts right by CHUNK.
  - The partial sum is CW bits and never overflows.
  - The K-th add occurs at edge N+K. At that edge:
    - count <= final sum.
    - done=1 and busy=0.
    - State goes to DONE.
  - start is ignored in BUSY and DONE; no queuing.
  - din and acc_en changes after capture have no effect.
- DONE:
  - done is high for exactly one cycle, then the state returns to IDLE.
  - Minimum start-to-start spacing is K+2 cycles.
- count holds its value until the next DONE; it is not cleared at start.
- Accumulate:
  - At edge N+K, if the latched acc_en=1: total <= min(total+count, 2^ACC_W-1).
  - If the true sum exceeds the maximum, total_ovf <= 1 (sticky).
  - If acc_en=0, total is unchanged.
- clear:
  - Effective at any edge in any state: total <= 0, total_ovf <= 0.
  - If clear coincides with an accumulate edge, clear wins and that word is not added. count and done are unaffected.
- K=1 (CHUNK=WIDTH): done is high one cycle after the start edge; behaviour is otherwise identical.
- Reset mid-operation aborts the word: no done pulse, and count/total return to 0.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately; state IDLE after release.
- WIDTH=32, CHUNK=4, din=0xFFFFFFFF, start at edge N -> busy high for edges N..N+7, done high for one cycle after edge N+8, count=32.
- Boundary values:
  - din=0x80000001 -> count=2.
  - din=0x00000000 -> count=0.
  - din=0xF0F0F0F0 -> count=16.
  - CHUNK=1 gives the same counts with done after 32 cycles.
  - CHUNK=32 gives done one cycle after start.
- Accumulate:
  - 0xF0F0F0F0, 0xFFFFFFFF, 0x00000001 with acc_en=1 -> total=49, total_ovf=0.
  - Next word 0xFF with acc_en=0 -> count=8, total stays 49.
- Saturation and clear, ACC_W=6:
  - Two words of 0xFFFFFFFF with acc_en=1 -> total=63, total_ovf=1.
  - clear asserted on the same edge as a third accumulate -> total=0, total_ovf=0, count=32.
- Protocol abuse:
  - start held high throughout -> words accepted only in IDLE (every K+2 cycles); din changed during BUSY does not alter count.
  - rst pulsed at the 3rd BUSY cycle -> no done, busy=0, count=0.

Source files
------------

// File: rtl/popcount_seq.sv
// Multi-cycle population counter: CHUNK bits per clock over a WIDTH-bit word,
// with a start/busy/done handshake and a saturating running total.
module popcount_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4,
    parameter int ACC_W = 16,
    localparam int K  = WIDTH / CHUNK,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             acc_en,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    count,
    output logic [ACC_W-1:0] total,
    output logic             total_ovf
);

    localparam int IW = (K > 1) ? $clog2(K) : 1;

    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH ||
        (WIDTH % CHUNK) != 0 || ACC_W < CW) begin : g_bad_params
        $error("popcount_seq: illegal WIDTH/CHUNK/ACC_W combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sh_q;
    logic [CW-1:0]    psum_q;
    logic [IW-1:0]    idx_q;
    logic             acc_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    count_q;
    logic [ACC_W-1:0] total_q, total_d;
    logic             ovf_q, ovf_d;

    function automatic logic [CW-1:0] pc_chunk(input logic [CHUNK-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < CHUNK; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    logic [CW-1:0]  sum_nx;
    logic           last;
    logic [ACC_W:0] sum_w;

    assign sum_nx = psum_q + pc_chunk(sh_q[CHUNK-1:0]);
    assign last   = (idx_q == IW'(K - 1));
    assign sum_w  = {1'b0, total_q} + (ACC_W + 1)'(sum_nx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            psum_q  <= '0;
            idx_q   <= '0;
            acc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sh_q    <= din;
                        acc_q   <= acc_en;
                        psum_q  <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    sh_q   <= sh_q >> CHUNK;
                    psum_q <= sum_nx;
                    idx_q  <= idx_q + 1'b1;
                    if (last) begin
                        count_q <= sum_nx;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // clear takes priority over an accumulate landing on the same edge
    always_comb begin
        total_d = total_q;
        ovf_d   = ovf_q;
        if (clear) begin
            total_d = '0;
            ovf_d   = 1'b0;
        end else if (state_q == S_BUSY && last && acc_q) begin
            if (sum_w[ACC_W]) begin
                total_d = '1;
                ovf_d   = 1'b1;
            end else begin
                total_d = sum_w[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            total_q <= total_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;
    assign total     = total_q;
    assign total_ovf = ovf_q;

endmodule
